// File: rtl/clock_switcher_pkg.sv
// Shared types and helpers for the glitch-free N-input clock switcher.
package clock_switcher_pkg;

    // Largest number of source clocks a switcher instance may multiplex.
    localparam int unsigned MAX_CLKS = 16;

    // Control FSM states: waiting for the reset clock, idle, switch in flight.
    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StIdle   = 2'd1,
        StSwitch = 2'd2
    } sw_state_e;

    // One-hot vector with bit idx set; all zero when idx is not below n.
    function automatic logic [MAX_CLKS-1:0] onehot(input int unsigned idx,
                                                   input int unsigned n);
        logic [MAX_CLKS-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < MAX_CLKS; k++) begin
            r[k] = (k == idx) && (k < n);
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_switcher_chain.sv
// Negedge synchronizer chain producing one clock-gate enable. Updates only while
// the source clock is low so the enable never changes under a high phase.
module clock_switcher_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_q;
    logic [SYNC_STAGES-1:0] stage_d;

    // Shift the request one stage deeper on every falling source edge.
    always_comb begin
        stage_d    = '0;
        stage_d[0] = d;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Chain flops: falling-edge clocked, cleared asynchronously so the gate
    // shuts immediately on reset.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Last stage is the gate enable.
    always_comb begin
        q = stage_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/clock_switcher_n.sv
// Glitch-free N-input clock multiplexer with a val/rdy switch handshake.
// Control logic runs on the generated clock, so it is frozen during the gap.
module clock_switcher_n
    import clock_switcher_pkg::*;
#(
    parameter int unsigned NUM_CLKS    = 4,
    parameter int unsigned SEL_W       = $clog2(NUM_CLKS),
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESET_SEL   = 0
) (
    output logic                clk_out,
    input  logic                reset,
    input  logic [NUM_CLKS-1:0] clk_in,
    input  logic                switch_val,
    output logic                switch_rdy,
    input  logic [SEL_W-1:0]    switch_msg,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                switch_err
);

    localparam logic [SEL_W-1:0] ResetSelIdx = SEL_W'(RESET_SEL);

    logic [NUM_CLKS-1:0] en_last;
    logic [NUM_CLKS-1:0] chain_d;
    logic                en_is_sel;
    logic                en_is_reset;

    sw_state_e        state_q,   state_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             rdy_q,     rdy_d;
    logic             err_q,     err_d;

    // Chain i requests its clock only when selected and every other gate is
    // shut; this feedback is what keeps at most one enable high.
    always_comb begin
        chain_d = '0;
        for (int unsigned i = 0; i < NUM_CLKS; i++) begin
            chain_d[i] = (32'(sel_q) == i) &&
                         ((en_last & ~(NUM_CLKS'(1) << i)) == '0);
        end
    end

    // One synchronizer chain per source, clocked by that source.
    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chain
        clock_switcher_chain #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chain (
            .clk   (clk_in[g]),
            .reset (reset),
            .d     (chain_d[g]),
            .q     (en_last[g])
        );
    end

    // Clock path: pure AND-OR of sources and their enables, nothing else.
    always_comb begin
        clk_out = |(clk_in & en_last);
    end

    // Decode whether the live enable matches the selected or reset source.
    always_comb begin
        en_is_sel   = (MAX_CLKS'(en_last) == onehot(32'(sel_q), NUM_CLKS));
        en_is_reset = (MAX_CLKS'(en_last) == onehot(RESET_SEL, NUM_CLKS));
    end

    // Handshake FSM next state; rdy/err/cur_sel are registered outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cur_sel_d = cur_sel_q;
        rdy_d     = rdy_q;
        err_d     = 1'b0;
        unique case (state_q)
            StInit: begin
                if (en_is_reset) begin
                    state_d = StIdle;
                    rdy_d   = 1'b1;
                end
            end
            StIdle: begin
                if (switch_val && rdy_q) begin
                    if (32'(switch_msg) >= NUM_CLKS) begin
                        err_d = 1'b1;
                    end else if (switch_msg != cur_sel_q) begin
                        sel_d   = switch_msg;
                        state_d = StSwitch;
                        rdy_d   = 1'b0;
                    end
                end
            end
            StSwitch: begin
                // Any edge here comes from either the old or the new source;
                // only a new-source edge completes the switch.
                if (en_is_sel) begin
                    cur_sel_d = sel_q;
                    state_d   = StIdle;
                    rdy_d     = 1'b1;
                end
            end
            default: begin
                state_d = StInit;
                rdy_d   = 1'b0;
            end
        endcase
    end

    // Control state, clocked by the generated clock.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q   <= StInit;
            sel_q     <= ResetSelIdx;
            cur_sel_q <= ResetSelIdx;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cur_sel_q <= cur_sel_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
        end
    end

    // Drive handshake and status outputs straight from their registers.
    always_comb begin
        switch_rdy = rdy_q;
        cur_sel    = cur_sel_q;
        switch_err = err_q;
    end

endmodule

// File: tb/tb_clock_switcher_n.sv
// Directed plus randomized bench for clock_switcher_n. Five sources are used so
// that an out-of-range index (5..7) fits in the 3-bit select.
`timescale 1ns/1ps
module tb_clock_switcher_n;

    localparam int unsigned NClks      = 5;
    localparam int unsigned SyncStages = 2;
    localparam int          Half [NClks] = '{5, 7, 11, 17, 23};
    localparam int          MinHigh    = 5;

    logic c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, c4 = 1'b0;
    logic [NClks-1:0] clk_in;
    logic             clk_out;
    logic             reset;
    logic             switch_val;
    logic             switch_rdy;
    logic [2:0]       switch_msg;
    logic [2:0]       cur_sel;
    logic             switch_err;

    int  checks = 0;
    int  errors = 0;
    int  model_cur = 0;
    bit  busy = 1'b1;
    int  pos_cnt = 0;
    int  acc_cnt = 0;
    time rise_t = 0;
    time fall_t = 0;
    time last_lo = 0;

    assign clk_in = {c4, c3, c2, c1, c0};

    // Unrelated sources with random start phases.
    initial begin #($urandom_range(0, 9));  forever #5  c0 = ~c0; end
    initial begin #($urandom_range(0, 13)); forever #7  c1 = ~c1; end
    initial begin #($urandom_range(0, 21)); forever #11 c2 = ~c2; end
    initial begin #($urandom_range(0, 33)); forever #17 c3 = ~c3; end
    initial begin #($urandom_range(0, 45)); forever #23 c4 = ~c4; end

    clock_switcher_n #(
        .NUM_CLKS    (NClks),
        .SYNC_STAGES (SyncStages),
        .RESET_SEL   (0)
    ) dut (
        .clk_out    (clk_out),
        .reset      (reset),
        .clk_in     (clk_in),
        .switch_val (switch_val),
        .switch_rdy (switch_rdy),
        .switch_msg (switch_msg),
        .cur_sel    (cur_sel),
        .switch_err (switch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Rising edges: count, log handshakes, and check the stable output clock.
    always @(posedge clk_out) begin
        pos_cnt++;
        if (switch_val && switch_rdy) acc_cnt++;
        last_lo = $time - fall_t;
        if (!busy && !reset) begin
            check("lo_width", 32'(last_lo), 32'(Half[model_cur]));
            check("cur_sel_live", 32'(cur_sel), 32'(model_cur));
            check("src_drive", 32'(clk_in[model_cur]), 1);
        end
        rise_t = $time;
    end

    // Falling edges: no runt pulses; exact source half-period while stable.
    always @(negedge clk_out) begin
        if (!reset) begin
            check("hi_min", 32'(($time - rise_t) >= MinHigh), 1);
            if (!busy) check("hi_width", 32'($time - rise_t), 32'(Half[model_cur]));
        end
        fall_t = $time;
    end

    always @(dut.en_last) begin
        check("en_onehot0", 32'($onehot0(dut.en_last)), 1);
    end

    task automatic wait_pos(input int n, output bit ok);
        int p0;
        p0 = pos_cnt;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (pos_cnt - p0 >= n) begin ok = 1'b1; break; end
            #1;
        end
    endtask

    task automatic wait_rdy(input int limit, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < limit; t++) begin
            if (switch_rdy === 1'b1) begin ok = 1'b1; break; end
            #1;
        end
    endtask

    // Issue one request and check the outcome against the behavioural model.
    task automatic do_req(input int msg);
        bit ok;
        int a0;
        wait_pos(1, ok);
        #1;
        switch_msg = 3'(msg);
        switch_val = 1'b1;
        a0 = acc_cnt;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            if (acc_cnt != a0) begin ok = 1'b1; break; end
            #1;
        end
        #1;
        switch_val = 1'b0;
        check("accept", 32'(ok), 1);
        if (!ok) return;
        if (msg >= int'(NClks)) begin
            check("err_pulse", 32'(switch_err), 1);
            check("err_rdy", 32'(switch_rdy), 1);
            check("err_cur", 32'(cur_sel), 32'(model_cur));
            wait_pos(1, ok);
            #1;
            check("err_clear", 32'(switch_err), 0);
            check("err_cur2", 32'(cur_sel), 32'(model_cur));
        end else if (msg == model_cur) begin
            check("same_rdy", 32'(switch_rdy), 1);
            check("same_err", 32'(switch_err), 0);
            check("same_cur", 32'(cur_sel), 32'(model_cur));
        end else begin
            busy = 1'b1;
            check("sw_rdy_low", 32'(switch_rdy), 0);
            wait_rdy(1000, ok);
            check("sw_done", 32'(ok), 1);
            check("sw_gap", 32'(last_lo >= Half[msg]), 1);
            model_cur = msg;
            busy = 1'b0;
            check("sw_cur", 32'(cur_sel), 32'(msg));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit      ok;
        int      p0;
        realtime rel;
        reset      = 1'b1;
        switch_val = 1'b0;
        switch_msg = '0;

        #20;
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_rdy", 32'(switch_rdy), 0);
        check("rst_err", 32'(switch_err), 0);
        check("rst_cur", 32'(cur_sel), 0);
        check("rst_en", 32'(dut.en_last), 0);

        // Release away from any source edge.
        #0.5;
        reset = 1'b0;
        rel = $realtime;
        p0 = pos_cnt;
        wait_pos(1, ok);
        check("start_edge", 32'(ok), 1);
        check("start_lat", 32'((real'(rise_t) - rel) <= real'(SyncStages * 10 + 6)), 1);
        wait_rdy(200, ok);
        check("init_rdy", 32'(ok), 1);
        check("init_edges", 32'(pos_cnt - p0), 1);
        check("init_cur", 32'(cur_sel), 0);
        model_cur = 0;
        busy = 1'b0;

        do_req(2);  // real switch to the 22 ns clock
        do_req(5);  // out-of-range index
        do_req(2);  // same as current: no-op

        // Reset once the old gate has shut mid-switch.
        wait_pos(1, ok);
        #1;
        switch_msg = 3'd3;
        switch_val = 1'b1;
        p0 = acc_cnt;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            if (acc_cnt != p0) begin ok = 1'b1; break; end
            #1;
        end
        #1;
        switch_val = 1'b0;
        busy = 1'b1;
        check("mid_accept", 32'(ok), 1);
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            if (dut.en_last[2] === 1'b0) begin ok = 1'b1; break; end
            #1;
        end
        check("mid_old_drop", 32'(ok), 1);
        #0.5;
        reset = 1'b1;
        #0.1;
        check("mid_clk_low", 32'(clk_out), 0);
        check("mid_en_clear", 32'(dut.en_last), 0);
        #30;
        reset = 1'b0;
        wait_rdy(200, ok);
        check("mid_rdy", 32'(ok), 1);
        check("mid_cur", 32'(cur_sel), 0);
        model_cur = 0;
        busy = 1'b0;

        // Random back-to-back traffic, including out-of-range and no-op requests.
        for (int n = 0; n < 40; n++) begin
            do_req(int'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) #($urandom_range(0, 30));
        end
        wait_pos(4, ok);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
